// File: rtl/morse_symbol_classifier.sv
// Morse key front end: synchronise, debounce, time marks/spaces and classify them
// into dit/dah/letter gap/word gap/error, delivered through a one-entry valid/ready slot.
//
// state    | meaning
// IDLE     | no measurement in progress, gaps suppressed
// MARK     | key down, timing the mark
// MARK_ERR | mark overran the error limit, waiting for key release
// SPACE    | key up after a symbol, timing the space for gap detection
module morse_symbol_classifier #(
  parameter int UNIT_CYCLES = 66,
  parameter int DEBOUNCE    = 4,
  parameter int DAH_UNITS   = 2,
  parameter int LGAP_UNITS  = 2,
  parameter int WGAP_UNITS  = 5,
  parameter int ERR_UNITS   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal,
  output logic [2:0] sym,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       level,
  output logic       overflow
);

  localparam int CNT_MAX = ERR_UNITS * UNIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DB_W    = $clog2(DEBOUNCE + 1);

  localparam logic [CNT_W-1:0] L_HALF = CNT_W'(UNIT_CYCLES / 2);
  localparam logic [CNT_W-1:0] L_DAH  = CNT_W'(DAH_UNITS * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] L_LGAP = CNT_W'(LGAP_UNITS * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] L_WGAP = CNT_W'(WGAP_UNITS * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] L_ERR  = CNT_W'(CNT_MAX);

  localparam logic [2:0] SYM_DIT  = 3'b001;
  localparam logic [2:0] SYM_DAH  = 3'b010;
  localparam logic [2:0] SYM_LGAP = 3'b011;
  localparam logic [2:0] SYM_WGAP = 3'b100;
  localparam logic [2:0] SYM_ERR  = 3'b111;

  typedef enum logic [1:0] {IDLE, MARK, MARK_ERR, SPACE} state_t;

  state_t            state, state_d;
  logic              from_space, from_space_d;
  logic              sync1, sync2;
  logic [DB_W-1:0]   db_cnt;
  logic              level_q;
  logic [CNT_W-1:0]  cnt;
  logic              chg, rise, fall;
  logic              new_sym;
  logic [2:0]        new_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db_cnt <= '0;
      level  <= 1'b0;
    end else begin
      sync1 <= signal;
      sync2 <= sync1;
      if (sync2 != level) begin
        if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
          level  <= ~level;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // chg marks the first cycle of a new level; cnt then holds the length of the old one
  assign chg  = level ^ level_q;
  assign rise = chg & level;
  assign fall = chg & ~level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      level_q <= level;
      if (chg)
        cnt <= CNT_W'(1);
      else if (cnt != L_ERR)
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      from_space <= 1'b0;
    end else begin
      state      <= state_d;
      from_space <= from_space_d;
    end
  end

  always_comb begin
    state_d      = state;
    from_space_d = from_space;
    new_sym      = 1'b0;
    new_code     = 3'b000;
    case (state)
      IDLE: begin
        if (rise) begin
          state_d      = MARK;
          from_space_d = 1'b0;
        end
      end
      MARK: begin
        if (fall) begin
          if (cnt < L_HALF) begin
            state_d = from_space ? SPACE : IDLE;
          end else if (cnt < L_DAH) begin
            state_d  = SPACE;
            new_sym  = 1'b1;
            new_code = SYM_DIT;
          end else begin
            state_d  = SPACE;
            new_sym  = 1'b1;
            new_code = SYM_DAH;
          end
        end else if (cnt == L_ERR) begin
          state_d  = MARK_ERR;
          new_sym  = 1'b1;
          new_code = SYM_ERR;
        end
      end
      MARK_ERR: begin
        if (fall)
          state_d = SPACE;
      end
      SPACE: begin
        // a mark starting on a threshold cycle wins over the gap
        if (rise) begin
          state_d      = MARK;
          from_space_d = 1'b1;
        end else if (cnt == L_WGAP) begin
          state_d  = IDLE;
          new_sym  = 1'b1;
          new_code = SYM_WGAP;
        end else if (cnt == L_LGAP) begin
          new_sym  = 1'b1;
          new_code = SYM_LGAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym       <= 3'b000;
      sym_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (new_sym && (!sym_valid || sym_ready)) begin
        sym       <= new_code;
        sym_valid <= 1'b1;
      end else if (new_sym) begin
        overflow <= 1'b1;
      end else if (sym_valid && sym_ready) begin
        sym_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_morse_symbol_classifier.sv
// Directed bench for morse_symbol_classifier: table of single mark/space bursts
// plus hand sequences for multi-mark, glitch-in-space, back-pressure and reset.
module tb_morse_symbol_classifier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       signal = 1'b0;
  logic [2:0] sym;
  logic       sym_valid;
  logic       sym_ready = 1'b1;
  logic       level;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [2:0] q_sym[$];
  int         q_t[$];
  int         vrun = 0;
  int         vrun_max = 0;
  logic       level_seen = 1'b0;

  typedef struct {
    int         mark;
    int         space;
    int         nexp;
    logic [2:0] s0;
    logic [2:0] s1;
    logic [2:0] s2;
    logic       lvl;
  } vec_t;

  vec_t vecs[9];

  morse_symbol_classifier dut (
    .clk(clk), .rst_n(rst_n), .signal(signal), .sym(sym), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sym_valid && sym_ready) begin
      q_sym.push_back(sym);
      q_t.push_back(cyc);
    end
    if (sym_valid) begin
      vrun = vrun + 1;
      if (vrun > vrun_max) vrun_max = vrun;
    end else begin
      vrun = 0;
    end
    if (level) level_seen = 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_mon();
    q_sym.delete();
    q_t.delete();
    vrun_max = 0;
    level_seen = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    signal = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_mon();
  endtask

  task automatic drive(input logic v, input int n);
    signal = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_sym(input string name, input int k, input logic [2:0] exp);
    if (k < q_sym.size()) chk(name, int'(q_sym[k]), int'(exp));
    else chk(name, -1, int'(exp));
  endtask

  initial begin
    vecs[0] = '{66,  400, 3, 3'b001, 3'b011, 3'b100, 1'b1};
    vecs[1] = '{198, 400, 3, 3'b010, 3'b011, 3'b100, 1'b1};
    vecs[2] = '{33,  400, 3, 3'b001, 3'b011, 3'b100, 1'b1};
    vecs[3] = '{32,  400, 0, 3'b000, 3'b000, 3'b000, 1'b1};
    vecs[4] = '{132, 400, 3, 3'b010, 3'b011, 3'b100, 1'b1};
    vecs[5] = '{131, 400, 3, 3'b001, 3'b011, 3'b100, 1'b1};
    vecs[6] = '{3,   100, 0, 3'b000, 3'b000, 3'b000, 1'b0};
    vecs[7] = '{500, 400, 3, 3'b111, 3'b011, 3'b100, 1'b1};
    vecs[8] = '{20,  100, 0, 3'b000, 3'b000, 3'b000, 1'b1};

    // reset values
    #1;
    chk("rst_sym", int'(sym), 0);
    chk("rst_valid", int'(sym_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_overflow", int'(overflow), 0);

    for (int v = 0; v < 9; v++) begin
      do_reset();
      drive(1'b1, vecs[v].mark);
      drive(1'b0, vecs[v].space);
      chk($sformatf("v%0d_count", v), q_sym.size(), vecs[v].nexp);
      for (int k = 0; k < vecs[v].nexp; k++)
        chk_sym($sformatf("v%0d_sym%0d", v, k), k,
                (k == 0) ? vecs[v].s0 : (k == 1) ? vecs[v].s1 : vecs[v].s2);
      chk($sformatf("v%0d_level", v), int'(level_seen), int'(vecs[v].lvl));
      if (vecs[v].nexp > 0) chk($sformatf("v%0d_pulse", v), vrun_max, 1);
      if (v == 0 && q_t.size() == 3) begin
        chk("lgap_spacing", q_t[1] - q_t[0], 132);
        chk("wgap_spacing", q_t[2] - q_t[1], 198);
      end
    end

    // dit then dah, no gap in between
    do_reset();
    drive(1'b1, 66);
    drive(1'b0, 66);
    drive(1'b1, 198);
    drive(1'b0, 30);
    chk("ditdah_count", q_sym.size(), 2);
    chk_sym("ditdah_0", 0, 3'b001);
    chk_sym("ditdah_1", 1, 3'b010);
    chk("ditdah_pulse", vrun_max, 1);

    // glitch during a space keeps the space state; count restarts at glitch fall
    do_reset();
    drive(1'b1, 66);
    drive(1'b0, 60);
    drive(1'b1, 20);
    drive(1'b0, 400);
    chk("gspace_count", q_sym.size(), 3);
    chk_sym("gspace_0", 0, 3'b001);
    chk_sym("gspace_1", 1, 3'b011);
    chk_sym("gspace_2", 2, 3'b100);
    if (q_t.size() == 3) chk("gspace_lgap_t", q_t[1] - q_t[0], 212);
    else chk("gspace_lgap_t", -1, 212);

    // back-pressure
    do_reset();
    sym_ready = 1'b0;
    drive(1'b1, 66);
    drive(1'b0, 66);
    drive(1'b1, 198);
    drive(1'b0, 20);
    chk("bp_sym", int'(sym), 1);
    chk("bp_valid", int'(sym_valid), 1);
    chk("bp_overflow", int'(overflow), 1);
    sym_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", int'(sym_valid), 0);
    chk("bp_overflow_sticky", int'(overflow), 1);

    // reset mid-mark, overflow still set from above
    drive(1'b1, 106);
    chk("mid_level_high", int'(level), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_sym", int'(sym), 0);
    chk("mid_rst_valid", int'(sym_valid), 0);
    chk("mid_rst_overflow", int'(overflow), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("mid_level_wait", int'(level), 0);
    repeat (67) @(negedge clk);
    chk("mid_no_sym_yet", q_sym.size(), 0);
    drive(1'b0, 50);
    chk("mid_count", q_sym.size(), 1);
    chk_sym("mid_dit", 0, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_symbol_classifier.md
# morse_symbol_classifier

Parametrised Morse front end: synchronises and debounces the raw key `signal`, measures mark and space durations in clock cycles, and classifies them as dit, dah, letter gap, word gap or error. Thresholds are expressed in "units" of `UNIT_CYCLES` clocks. Results are delivered one at a time through a single-entry valid/ready output register to the downstream letter decoder. It is the next-generation dit/dah counter: configurable timing, glitch rejection, gap detection and back-pressure.

## Interface
- `UNIT_CYCLES`, 66: clocks per Morse unit.
- `DEBOUNCE`, 4: consecutive equal synchronised samples required to accept a level change (≥1).
- `DAH_UNITS`, 2: a mark of at least `DAH_UNITS*UNIT_CYCLES` cycles is a dah.
- `LGAP_UNITS`, 2: space length that emits a letter gap.
- `WGAP_UNITS`, 5: space length that emits a word gap (> `LGAP_UNITS`).
- `ERR_UNITS`, 6: mark length that emits an error (> `DAH_UNITS`).
- localparam `CNT_W` = clog2(`ERR_UNITS*UNIT_CYCLES`+1): width of the duration counter.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `signal`  in  1  raw key level, asynchronous; 1 = mark (tone on).
- `sym`  out  3  symbol code: 001 dit, 010 dah, 011 letter gap, 100 word gap, 111 error.
- `sym_valid`  out  1  `sym` holds an unconsumed symbol.
- `sym_ready`  in  1  consumer accepts `sym` this cycle.
- `level`  out  1  debounced key level.
- `overflow`  out  1  sticky: a symbol was dropped; cleared only by reset.

## Operation
- **Input conditioning.** `signal` passes through a 2-flop synchroniser, then the debouncer. `level` toggles only after `DEBOUNCE` consecutive synchronised samples differ from the current `level`. Shorter pulses are ignored completely.
- **Duration counter.**
  - Loads 1 on the cycle `level` changes; otherwise increments.
  - Saturates at `ERR_UNITS*UNIT_CYCLES`.
  - L is the count of cycles during which `level` held its value.
- **FSM states:** IDLE, MARK, MARK_ERR, SPACE.
  - IDLE: `level` rises → MARK. No gap symbols are emitted while in IDLE.
  - MARK, `level` falls with L < `UNIT_CYCLES/2`: the mark is treated as a glitch. No symbol is emitted; the FSM returns to the state it was in before the mark (IDLE or SPACE). The space count resumes from 1.
  - MARK, `level` falls with `UNIT_CYCLES/2` ≤ L < `DAH_UNITS*UNIT_CYCLES`: emit dit, go to SPACE.
  - MARK, `level` falls with `DAH_UNITS*UNIT_CYCLES` ≤ L: emit dah, go to SPACE.
  - MARK, counter reaches `ERR_UNITS*UNIT_CYCLES` while `level` is still 1: emit error immediately, go to MARK_ERR.
  - MARK_ERR, `level` falls: go to SPACE. No symbol is emitted.
  - SPACE, count reaches exactly `LGAP_UNITS*UNIT_CYCLES`: emit letter gap (once).
  - SPACE, count reaches exactly `WGAP_UNITS*UNIT_CYCLES`: emit word gap, go to IDLE.
  - SPACE, `level` rises: go to MARK.
- **Output register.**
  - A symbol loads when `sym_valid`=0, or when `sym_valid`=1 and `sym_ready`=1 in the same cycle.
  - If `sym_valid`=1 and `sym_ready`=0 when a symbol is produced, the new symbol is dropped and `overflow` sets. The held symbol is unchanged.
  - `sym_valid`=1 with `sym_ready`=1 and no new symbol: `sym_valid` clears next cycle.
  - `sym` is stable while `sym_valid`=1.

## Timing
- **Reset** (asynchronous, immediate): state IDLE, counter 0, synchroniser flops 0, `level`=0, `sym`=000, `sym_valid`=0, `overflow`=0. Reset asserted mid-mark or mid-space discards the partial measurement; no symbol is emitted on release.
- **Input latency:** a clean edge on `signal` appears on `level` 2+`DEBOUNCE` cycles later.
- **Classification latency:** `sym_valid` rises 1 cycle after the classifying event, i.e. after the `level` fall edge or the threshold-reaching count.
- **Gap timing:** the letter gap is emitted at space count `LGAP_UNITS*UNIT_CYCLES`, not at the next mark.
- **Throughput:** one symbol per cycle maximum. Symbols are at least `UNIT_CYCLES/2` cycles apart by construction.
- **Boundaries:**
  - L exactly `DAH_UNITS*UNIT_CYCLES` → dah.
  - L exactly `UNIT_CYCLES/2` → dit.
  - A mark starting on the same cycle the space count hits the letter threshold counts as a mark start; no gap is emitted.

## Test plan
Bench defaults: `UNIT_CYCLES`=66, `DEBOUNCE`=4; `sym_ready` tied to 1 unless stated otherwise.
- **Dit/dah.** 66-cycle mark, then 66-cycle space, then 198-cycle mark → dit, then dah. No gap between them. `sym_valid` is a 1-cycle pulse each time.
- **Letter and word gaps.** After a dit, hold `signal`=0 for 400 cycles → letter gap at space count 132, word gap at 330, then nothing more (IDLE).
- **Glitch rejection.**
  - 3-cycle pulse → `level` never changes; no symbol.
  - 20-cycle mark → `level` toggles; no symbol; space/IDLE state is preserved.
- **Error.** Hold `signal`=1 for 500 cycles → error emitted when the count reaches 396; no symbol on release. A later 66-cycle mark → dit.
- **Back-pressure.** `sym_ready`=0; send dit, dah → `sym`=001 held, `overflow`=1. Raise `sym_ready` → `sym_valid` drops the next cycle.
- **Reset mid-mark.** Pulse `rst_n` low 100 cycles into a mark → all outputs 0 immediately. After release with `signal` still high, the mark restarts counting from the new `level` rise.
